timer_dev: RTL and testbench

Memory-mapped countdown timer peripheral that raises a hardware interrupt line into the CP0 `hwirq[5:0]` bus. The CPU programs it through word-addressed store/load accesses forwarded by the system bridge. On expiry it asserts `irq`, which the top level wires to one `hwirq` bit so CP0 can take an `EXC_INT`. It supports one-shot mode and, optionally, periodic auto-reload mode.

---
 rtl/timer_dev.sv | 184 ++++++++++++++++++
 tb/tb_timer_dev.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer that drives one line of the CP0
// hardware interrupt bus.
//
// Register map (word select addr = byte address bits [3:2]):
//   0 CTRL   [0] EN, [2:1] MODE, [3] IM (interrupt mask, 1 = enabled)
//   1 PRESET reload value, read/write
//   2 COUNT  current count, read-only
//   3 reserved, reads 0, writes ignored
//
// Optional feature macro: TIMER_AUTO_RELOAD_EN
//   defined     : MODE is stored; MODE 1 reloads PRESET after every expiry and
//                 pulses irq for one cycle per period.
//   not defined : MODE is not stored and reads 0; every run is one-shot.
//
// A register write and the FSM may update the same field on the same edge;
// the write always wins for the fields it touches.

module timer_dev #(
  parameter int unsigned COUNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        write_enable,
  input  logic [31:0] write_data,
  output logic [31:0] read_result,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam logic [COUNT_W-1:0] COUNT_ONE  = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] COUNT_ZERO = '0;

  state_t               state_q, state_d;
  logic                 en_q, en_d;
  logic                 im_q, im_d;
  logic [COUNT_W-1:0]   preset_q, preset_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 pending_q, pending_d;

`ifdef TIMER_AUTO_RELOAD_EN
  logic [1:0]           mode_q, mode_d;
`endif

  logic                 ctrl_wr;
  logic                 preset_wr;
  logic                 reload_mode;
  logic [1:0]           mode_rd;

  // Decode the write strobe into per-register write enables.
  always_comb begin
    ctrl_wr   = write_enable && (addr == ADDR_CTRL);
    preset_wr = write_enable && (addr == ADDR_PRESET);
  end

  // Resolve the effective mode; MODE 2/3 behave like one-shot.
  always_comb begin
`ifdef TIMER_AUTO_RELOAD_EN
    reload_mode = (mode_q == 2'd1);
    mode_rd     = mode_q;
`else
    reload_mode = 1'b0;
    mode_rd     = 2'b00;
`endif
  end

  // Next-state logic: FSM progress first, then register writes override
  // whichever fields they touch.
  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    im_d      = im_q;
    preset_d  = preset_q;
    count_d   = count_q;
    pending_d = pending_q;
`ifdef TIMER_AUTO_RELOAD_EN
    mode_d    = mode_q;
`endif

    case (state_q)
      IDLE: begin
        if (en_q) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!en_q) begin
          state_d = IDLE;
        end else if (count_q > COUNT_ONE) begin
          count_d = count_q - COUNT_ONE;
        end else begin
          count_d   = COUNT_ZERO;
          pending_d = 1'b1;
          if (reload_mode) begin
            state_d = INT;
          end else begin
            en_d    = 1'b0;
            state_d = IDLE;
          end
        end
      end
      INT: begin
        pending_d = 1'b0;
        state_d   = LOAD;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (ctrl_wr) begin
      en_d      = write_data[0];
      im_d      = write_data[3];
      pending_d = 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
      mode_d    = write_data[2:1];
`endif
      if (!write_data[0]) begin
        state_d = IDLE;
      end
    end

    if (preset_wr) begin
      preset_d  = write_data[COUNT_W-1:0];
      pending_d = 1'b0;
    end
  end

  // State and register flops with synchronous reset to all zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      en_q      <= 1'b0;
      im_q      <= 1'b0;
      preset_q  <= COUNT_ZERO;
      count_q   <= COUNT_ZERO;
      pending_q <= 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
      mode_q    <= 2'b00;
`endif
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      im_q      <= im_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      pending_q <= pending_d;
`ifdef TIMER_AUTO_RELOAD_EN
      mode_q    <= mode_d;
`endif
    end
  end

  // Zero-latency read mux; unused upper bits and the reserved word read 0.
  always_comb begin
    read_result = '0;
    case (addr)
      ADDR_CTRL:   read_result = {28'd0, im_q, mode_rd, en_q};
      ADDR_PRESET: read_result[COUNT_W-1:0] = preset_q;
      ADDR_COUNT:  read_result[COUNT_W-1:0] = count_q;
      default:     read_result = '0;
    endcase
  end

  // Interrupt is the masked pending flag, so it only moves on clock edges.
  always_comb begin
    irq = pending_q & im_q;
  end

endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: directed test of timer_dev with a scoreboard. Each stimulus
// cycle pushes the expected read_result/irq for that cycle; a monitor pops
// and compares on the falling edge.

module tb_timer_dev;

  localparam int unsigned COUNT_W = 32;

  logic        clk;
  logic        rst;
  logic [1:0]  addr;
  logic        write_enable;
  logic [31:0] write_data;
  logic [31:0] read_result;
  logic        irq;

  typedef struct {
    logic [31:0] rd;
    logic        irq_v;
    bit          chk_rd;
    bit          chk_irq;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  logic [31:0] exp_cnt_m[13];
  logic        exp_irq_m[13];

  timer_dev #(.COUNT_W(COUNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .write_enable (write_enable),
    .write_data   (write_data),
    .read_result  (read_result),
    .irq          (irq)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, queue the expected outputs for that cycle,
  // then advance to just after the next rising edge.
  task automatic applyStimulus(input logic r, input logic [1:0] a, input logic we,
                               input logic [31:0] wd, input logic [31:0] exp_rd,
                               input bit chk_rd, input logic exp_irq,
                               input bit chk_irq, input string tag);
    exp_t e;
    rst          = r;
    addr         = a;
    write_enable = we;
    write_data   = wd;
    e.rd      = exp_rd;
    e.irq_v   = exp_irq;
    e.chk_rd  = chk_rd;
    e.chk_irq = chk_irq;
    e.tag     = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic readReg(input logic [1:0] a, input logic [31:0] exp_rd,
                         input logic exp_irq, input string tag);
    applyStimulus(1'b0, a, 1'b0, 32'd0, exp_rd, 1'b1, exp_irq, 1'b1, tag);
  endtask

  task automatic writeReg(input logic [1:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_irq,
                          input string tag);
    applyStimulus(1'b0, a, 1'b1, wd, exp_rd, 1'b1, exp_irq, 1'b1, tag);
  endtask

  // Compare one scoreboard entry against the live DUT outputs.
  task automatic checkOutput(input exp_t e);
    if (e.chk_rd) begin
      vectors++;
      if (read_result !== e.rd) begin
        miscompares++;
        $display("[TB] FAIL %s read_result: got 0x%08h, expected 0x%08h",
                 e.tag, read_result, e.rd);
      end
    end
    if (e.chk_irq) begin
      vectors++;
      if (irq !== e.irq_v) begin
        miscompares++;
        $display("[TB] FAIL %s irq: got %b, expected %b", e.tag, irq, e.irq_v);
      end
    end
  endtask

  // Monitor: outputs are stable mid-cycle, so pop and compare on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      checkOutput(sb.pop_front());
    end
  end

  initial begin
`ifdef TIMER_AUTO_RELOAD_EN
    exp_cnt_m = '{32'd0, 32'd0, 32'd2, 32'd1, 32'd0, 32'd0, 32'd2, 32'd1, 32'd0,
                  32'd0, 32'd2, 32'd1, 32'd0};
    exp_irq_m = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                  1'b0, 1'b0, 1'b0, 1'b1};
`else
    exp_cnt_m = '{32'd0, 32'd0, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                  32'd0, 32'd0, 32'd0, 32'd0};
    exp_irq_m = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                  1'b1, 1'b1, 1'b1, 1'b1};
`endif
    rst          = 1'b1;
    addr         = 2'd0;
    write_enable = 1'b0;
    write_data   = 32'd0;
    @(posedge clk);
    #1;

    $display("[TB] reset and register map");
    applyStimulus(1'b1, 2'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, "reset_a");
    applyStimulus(1'b1, 2'd0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, "reset_b");
    readReg(2'd0, 32'd0, 1'b0, "rst_ctrl");
    readReg(2'd1, 32'd0, 1'b0, "rst_preset");
    readReg(2'd2, 32'd0, 1'b0, "rst_count");
    readReg(2'd3, 32'd0, 1'b0, "rst_resv");
    writeReg(2'd2, 32'd5, 32'd0, 1'b0, "wr_count");
    readReg(2'd2, 32'd0, 1'b0, "count_ro");
    writeReg(2'd3, 32'hFFFF_FFFF, 32'd0, 1'b0, "wr_resv");
    readReg(2'd3, 32'd0, 1'b0, "resv_ro");

    $display("[TB] one-shot P=3 with IM");
    writeReg(2'd1, 32'd3, 32'd0, 1'b0, "os_preset");
    writeReg(2'd0, 32'h9, 32'd0, 1'b0, "os_ctrl");
    readReg(2'd2, 32'd0, 1'b0, "os_idle");
    readReg(2'd2, 32'd0, 1'b0, "os_load");
    readReg(2'd2, 32'd3, 1'b0, "os_c3");
    readReg(2'd2, 32'd2, 1'b0, "os_c2");
    readReg(2'd2, 32'd1, 1'b0, "os_c1");
    readReg(2'd2, 32'd0, 1'b1, "os_c0");
    readReg(2'd0, 32'h8, 1'b1, "os_ctrl_rb");
    readReg(2'd2, 32'd0, 1'b1, "os_hold");
    writeReg(2'd0, 32'h0, 32'h8, 1'b1, "os_clr");
    readReg(2'd0, 32'h0, 1'b0, "os_cleared");

    $display("[TB] MODE 1 request, P=2");
    writeReg(2'd1, 32'd2, 32'd3, 1'b0, "ar_preset");
    writeReg(2'd0, 32'hB, 32'd0, 1'b0, "ar_ctrl");
    for (int i = 0; i < 13; i++) begin
      readReg(2'd2, exp_cnt_m[i], exp_irq_m[i], $sformatf("ar_cyc%0d", i + 1));
    end
`ifdef TIMER_AUTO_RELOAD_EN
    readReg(2'd0, 32'hB, 1'b0, "ar_ctrl_rb");
    writeReg(2'd0, 32'h0, 32'hB, 1'b0, "ar_stop");
    readReg(2'd2, 32'd2, 1'b0, "ar_held");
`else
    readReg(2'd0, 32'h8, 1'b1, "ar_ctrl_rb");
    writeReg(2'd0, 32'h0, 32'h8, 1'b1, "ar_stop");
    readReg(2'd2, 32'd0, 1'b0, "ar_held");
`endif

    $display("[TB] masked expiry P=4");
    writeReg(2'd1, 32'd4, 32'd2, 1'b0, "im_preset");
    writeReg(2'd0, 32'h1, 32'd0, 1'b0, "im_ctrl");
    applyStimulus(1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, "im_idle");
    applyStimulus(1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, "im_load");
    readReg(2'd2, 32'd4, 1'b0, "im_c4");
    readReg(2'd2, 32'd3, 1'b0, "im_c3");
    readReg(2'd2, 32'd2, 1'b0, "im_c2");
    readReg(2'd2, 32'd1, 1'b0, "im_c1");
    readReg(2'd2, 32'd0, 1'b0, "im_c0");
    readReg(2'd0, 32'h0, 1'b0, "im_ctrl_rb");
    writeReg(2'd0, 32'h8, 32'h0, 1'b0, "im_unmask");
    readReg(2'd0, 32'h8, 1'b0, "im_after");
    readReg(2'd2, 32'd0, 1'b0, "im_after2");

    $display("[TB] CTRL=0 on the expiry edge");
    writeReg(2'd1, 32'd2, 32'd4, 1'b0, "race_preset");
    writeReg(2'd0, 32'h9, 32'h8, 1'b0, "race_ctrl");
    readReg(2'd2, 32'd0, 1'b0, "race_idle");
    readReg(2'd2, 32'd0, 1'b0, "race_load");
    readReg(2'd2, 32'd2, 1'b0, "race_c2");
    writeReg(2'd0, 32'h0, 32'h9, 1'b0, "race_kill");
    readReg(2'd2, 32'd0, 1'b0, "race_cnt0");
    readReg(2'd0, 32'h0, 1'b0, "race_ctrl_rb");
    readReg(2'd2, 32'd0, 1'b0, "race_quiet");

    $display("[TB] reset mid-count P=10");
    writeReg(2'd1, 32'd10, 32'd2, 1'b0, "mr_preset");
    writeReg(2'd0, 32'h9, 32'h0, 1'b0, "mr_ctrl");
    readReg(2'd2, 32'd0, 1'b0, "mr_idle");
    readReg(2'd2, 32'd0, 1'b0, "mr_load");
    readReg(2'd2, 32'd10, 1'b0, "mr_c10");
    readReg(2'd2, 32'd9, 1'b0, "mr_c9");
    readReg(2'd2, 32'd8, 1'b0, "mr_c8");
    readReg(2'd2, 32'd7, 1'b0, "mr_c7");
    applyStimulus(1'b1, 2'd2, 1'b0, 32'd0, 32'd6, 1'b1, 1'b0, 1'b1, "mr_c6_rst");
    readReg(2'd0, 32'd0, 1'b0, "mr_ctrl0");
    readReg(2'd1, 32'd0, 1'b0, "mr_preset0");
    readReg(2'd2, 32'd0, 1'b0, "mr_count0");
    for (int i = 0; i < 14; i++) begin
      readReg(2'd2, 32'd0, 1'b0, $sformatf("mr_quiet%0d", i));
    end

    for (int i = 0; i < 5 && sb.size() > 0; i++) begin
      @(negedge clk);
    end
    if (sb.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d entries left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
